writeback_arbiter: RTL and testbench
====================================

# writeback_arbiter

Round-robin arbiter that shares the single writeback/commit port between the `NUM_UNITS` execution units (ALU, load/store, mul, div, CSR, …). Each unit presents a completed result (`id_t` plus `XLEN`-bit value). The arbiter grants one unit per cycle into a one-entry registered output stage that the register file / commit logic drains under a valid/ready handshake. It sits between the execution units and writeback. It sequences the shared port so that no unit starves and so that results are never dropped under backpressure.

## Interface
Parameters:
- `NUM_UNITS`, default `NUM_WB_UNITS` (taiga_config): number of requesting units, ≥1, need not be a power of two.
- `XLEN`, default 32: result width.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `unit_done`, in, `NUM_UNITS`: unit k has a result pending.
- `unit_id`, in, `NUM_UNITS` × `id_t`: instruction ID of unit k's result.
- `unit_rd`, in, `NUM_UNITS` × `XLEN`: result data of unit k.
- `unit_ack`, out, `NUM_UNITS`: one-hot; the result of unit k is captured this cycle.
- `wb_valid`, out, 1: the output stage holds a result.
- `wb_id`, out, `id_t`: ID of the held result.
- `wb_rd`, out, `XLEN`: data of the held result.
- `wb_unit`, out, `unit_id_t`: index of the unit that produced the held result.
- `wb_ready`, in, 1: downstream accepts the held result this cycle.

## Operation
- `load = !wb_valid | wb_ready`. The output stage can take a new entry only when `load` is high.
- Request scan starts at the priority pointer `ptr` and runs modulo `NUM_UNITS`. The first k with `unit_done[k]` wins.
- When `load` is high and any request exists, the arbiter:
  - raises `unit_ack[winner]` combinationally in the same cycle;
  - registers `wb_id`, `wb_rd` and `wb_unit` from the winner and sets `wb_valid` to 1;
  - updates `ptr` to winner+1, or to 0 when the winner is `NUM_UNITS-1` (explicit compare, no power-of-two masking).
- When `load` is high and there are no requests, `wb_valid` becomes 0 next cycle. `ptr`, `wb_id`, `wb_rd` and `wb_unit` are unchanged.
- When `load` is low, the output registers hold, all `unit_ack` are 0 and `ptr` holds.
- Unit contract:
  - `unit_done`, `unit_id` and `unit_rd` stay stable until the cycle of `unit_ack`.
  - The unit may drop `unit_done` or present a new result in the cycle after `unit_ack`.
  - A unit that deasserts `unit_done` before `unit_ack` is a protocol violation. The bench asserts on it.
- `NUM_UNITS = 1`: the pointer is a constant 0 and the block degenerates to a registered valid/ready stage.
- Reset values:
  - `wb_valid` = 0, `wb_id` = 0, `wb_rd` = 0, `wb_unit` = 0, `ptr` = 0.
  - `unit_ack` is forced to 0 while `rst` is high.
- Reset mid-operation drops any held entry. No ack is issued during reset, so unit results are not lost.

## Timing
- Latency: `unit_done` rising in cycle N with the stage empty gives `unit_ack` in cycle N and `wb_valid` in cycle N+1.
- Throughput: one result per cycle while `wb_ready` stays high.
- A simultaneous drain and refill (`wb_valid & wb_ready` with a pending request) replaces the entry with no bubble.
- Fairness: a continuously requesting unit is granted within `NUM_UNITS` accepted transfers.
- Combinational paths:
  - `wb_ready` → `unit_ack`;
  - `unit_done` → `unit_ack`.
- There is no combinational path from any input to `wb_*`.

## Structure
- Add to the shared types package: `wb_packet_t {id_t id; logic [XLEN-1:0] rd;}`.
- `unit_id_t` and `id_t` are already shared.
- Sub-module `rr_priority_encoder`:
  - inputs: request vector and pointer;
  - outputs: one-hot grant, winner index (`unit_id_t`), any-request flag;
  - purely combinational, reusable by other arbiters.
- The top level holds the pointer register, the output stage and the handshake logic.

## Test plan
All scenarios use `NUM_UNITS = 4`.
- Reset: assert `rst` for 2 cycles with all `unit_done` high → every `unit_ack` is 0, `wb_valid` = 0, all `wb_*` fields = 0; the first grant after reset goes to unit 0.
- Single request: unit 2 presents id 5, rd 0xDEADBEEF in cycle 0 with `wb_ready` = 1 → `unit_ack` = 4'b0100 in cycle 0; cycle 1 shows `wb_valid` = 1, `wb_id` = 5, `wb_rd` = 0xDEADBEEF, `wb_unit` = 2.
- Full contention: all 4 units request continuously, `wb_ready` = 1 → grant order 0, 1, 2, 3, 0, 1 on consecutive cycles with no bubble.
- Backpressure: the stage holds unit 1's result with `wb_ready` = 0 for 3 cycles while unit 3 requests → `wb_*` stable and `unit_ack` = 0 throughout; in the cycle `wb_ready` rises, `unit_ack[3]` = 1, and the next cycle shows `wb_unit` = 3.
- Wrap-around: grant unit 3, then units 0 and 3 request together → unit 0 is granted (`ptr` wrapped to 0); the next grant goes to unit 3.
- Reset mid-op: `wb_valid` = 1, `wb_ready` = 0, unit 2 pending, then `rst` for 1 cycle → `wb_valid` = 0 next cycle and no ack during reset; unit 2 is granted in the first cycle after reset.

Source files
------------

// File: rtl/writeback_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_pkg
// Shared types for the writeback path: instruction IDs, unit indices, the
// packet held in the writeback output stage, and the pointer-advance helper
// used by the round-robin arbiter.
// No ports (package).
// -----------------------------------------------------------------------------
package writeback_arbiter_pkg;

    // Core-wide configuration
    localparam int NUM_WB_UNITS = 4;
    localparam int WB_XLEN      = 32;
    localparam int ID_W         = 4;
    localparam int UNIT_ID_W    = 4;

    typedef logic [ID_W-1:0]      id_t;
    typedef logic [UNIT_ID_W-1:0] unit_id_t;

    typedef struct packed {
        id_t                id;
        logic [WB_XLEN-1:0] rd;
    } wb_packet_t;

    // The pointer moves just past the winner. An explicit compare against the
    // last unit keeps the wrap correct for unit counts that are not powers of two.
    function automatic unit_id_t nextPtr(unit_id_t winner, int numUnits);
        return (int'(winner) == numUnits - 1) ? '0 : winner + unit_id_t'(1);
    endfunction

endpackage

// File: rtl/writeback_arbiter_if.sv
// -----------------------------------------------------------------------------
// writeback_arbiter_if
// Bundles the execution-unit request side and the writeback drain side.
//   unit_done/unit_id/unit_rd : per-unit pending result (units -> arbiter)
//   unit_ack                  : one-hot capture strobe (arbiter -> units)
//   wb_valid/wb_id/wb_rd/wb_unit : held result (arbiter -> commit logic)
//   wb_ready                  : commit logic accepts the held result
// master = arbiter side, slave = environment (units + commit logic).
// -----------------------------------------------------------------------------
interface writeback_arbiter_if
    import writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = NUM_WB_UNITS,
    parameter int XLEN      = WB_XLEN
);

    logic [NUM_UNITS-1:0]           unit_done;
    id_t  [NUM_UNITS-1:0]           unit_id;
    logic [NUM_UNITS-1:0][XLEN-1:0] unit_rd;
    logic [NUM_UNITS-1:0]           unit_ack;

    logic                           wb_valid;
    id_t                            wb_id;
    logic [XLEN-1:0]                wb_rd;
    unit_id_t                       wb_unit;
    logic                           wb_ready;

    modport master (
        input  unit_done, unit_id, unit_rd, wb_ready,
        output unit_ack, wb_valid, wb_id, wb_rd, wb_unit
    );

    modport slave (
        output unit_done, unit_id, unit_rd, wb_ready,
        input  unit_ack, wb_valid, wb_id, wb_rd, wb_unit
    );

endinterface

// File: rtl/writeback_arbiter_rr_priority_encoder.sv
// -----------------------------------------------------------------------------
// rr_priority_encoder
// Purely combinational rotating-priority encoder. Scans the request vector
// starting at ptr_i, modulo NUM_UNITS, and reports the first requester.
//   req_i    : request vector
//   ptr_i    : index that currently has highest priority (must be < NUM_UNITS)
//   grant_o  : one-hot grant (all zero when nothing requests)
//   winner_o : index of the granted requester
//   anyReq_o : at least one request is present
// -----------------------------------------------------------------------------
module rr_priority_encoder
    import writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = NUM_WB_UNITS
) (
    input  logic [NUM_UNITS-1:0] req_i,
    input  unit_id_t             ptr_i,
    output logic [NUM_UNITS-1:0] grant_o,
    output unit_id_t             winner_o,
    output logic                 anyReq_o
);

    logic [2*NUM_UNITS-1:0] doubled;
    logic [NUM_UNITS-1:0]   rotated;
    int                     offset;
    int                     sum;

    // Rotate the requests so ptr_i lands at bit 0, take the lowest set bit,
    // then map the offset back to an absolute index with a single wrap.
    always_comb begin
        doubled  = {req_i, req_i} >> ptr_i;
        rotated  = doubled[NUM_UNITS-1:0];
        offset   = 0;
        anyReq_o = 1'b0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset   = i;
                anyReq_o = 1'b1;
            end
        end
        sum = int'(ptr_i) + offset;
        if (sum >= NUM_UNITS) begin
            sum = sum - NUM_UNITS;
        end
        winner_o = unit_id_t'(sum);
        grant_o  = anyReq_o ? (NUM_UNITS'(1) << winner_o) : '0;
    end

endmodule

// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
// Round-robin arbiter sharing the single writeback port between execution
// units. One unit is granted per cycle into a one-entry registered output
// stage drained under valid/ready.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : writeback_arbiter_if.master (unit requests/acks, writeback stage)
// -----------------------------------------------------------------------------
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int NUM_UNITS = NUM_WB_UNITS,
    parameter int XLEN      = WB_XLEN
) (
    input  logic                 clk,
    input  logic                 rst,
    writeback_arbiter_if.master  bus
);

    logic [NUM_UNITS-1:0] grant;
    unit_id_t             winner;
    logic                 anyReq;
    logic                 load;

    unit_id_t             ptr_q,     ptr_d;
    logic                 wbValid_q, wbValid_d;
    id_t                  wbId_q,    wbId_d;
    logic [XLEN-1:0]      wbRd_q,    wbRd_d;
    unit_id_t             wbUnit_q,  wbUnit_d;

    rr_priority_encoder #(
        .NUM_UNITS (NUM_UNITS)
    ) u_rrEnc (
        .req_i    (bus.unit_done),
        .ptr_i    (ptr_q),
        .grant_o  (grant),
        .winner_o (winner),
        .anyReq_o (anyReq)
    );

    // The stage can take a new entry when empty or being drained this cycle.
    // Acks are suppressed during reset so no unit result is lost to a flush.
    assign load         = !wbValid_q || bus.wb_ready;
    assign bus.unit_ack = (load && anyReq && !rst) ? grant : '0;

    // Next-state for the output stage and pointer. With no request the stage
    // empties but keeps its old payload and the pointer stays put.
    always_comb begin
        ptr_d     = ptr_q;
        wbValid_d = wbValid_q;
        wbId_d    = wbId_q;
        wbRd_d    = wbRd_q;
        wbUnit_d  = wbUnit_q;
        if (load) begin
            wbValid_d = anyReq;
            if (anyReq) begin
                for (int k = 0; k < NUM_UNITS; k++) begin
                    if (grant[k]) begin
                        wbId_d = bus.unit_id[k];
                        wbRd_d = bus.unit_rd[k];
                    end
                end
                wbUnit_d = winner;
                ptr_d    = nextPtr(winner, NUM_UNITS);
            end
        end
    end

    // State registers with synchronous reset; a reset drops any held entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            wbValid_q <= 1'b0;
            wbId_q    <= '0;
            wbRd_q    <= '0;
            wbUnit_q  <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wbValid_q <= wbValid_d;
            wbId_q    <= wbId_d;
            wbRd_q    <= wbRd_d;
            wbUnit_q  <= wbUnit_d;
        end
    end

    assign bus.wb_valid = wbValid_q;
    assign bus.wb_id    = wbId_q;
    assign bus.wb_rd    = wbRd_q;
    assign bus.wb_unit  = wbUnit_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// -----------------------------------------------------------------------------
// tb_writeback_arbiter
// Scoreboard bench for writeback_arbiter with four units. The driver issues
// one cycle of stimulus at a time, predicts the grant from the round-robin
// rule, and queues the expected writeback packet; an independent monitor pops
// and compares whenever the stage hands a result downstream.
// -----------------------------------------------------------------------------
module tb_writeback_arbiter;
    import writeback_arbiter_pkg::*;

    localparam int N = 4;

    typedef struct {
        wb_packet_t pkt;
        int         unit;
    } expEntry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    writeback_arbiter_if #(.NUM_UNITS(N), .XLEN(32)) bus ();

    writeback_arbiter #(.NUM_UNITS(N), .XLEN(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    expEntry_t   expQ[$];
    bit          pend[N];
    id_t         uid[N];
    logic [31:0] urd[N];
    bit          mValid = 1'b0;
    int          mPtr = 0;
    int          nCompared = 0;
    int          nMismatched = 0;
    bit          monEn = 1'b0;
    logic [N-1:0] prevDone = '0;
    logic [N-1:0] prevAck = '0;

    // Free-running clock
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock cycle of stimulus: drive at negedge, predict and check the
    // combinational ack, queue the captured packet, then advance the model.
    task automatic applyStimulus(input bit rstVal, input bit readyVal, output logic [N-1:0] ackSeen);
        logic [N-1:0] expAck;
        expEntry_t    e;
        int           win;
        bit           load;
        @(negedge clk);
        rst          = rstVal;
        bus.wb_ready = readyVal;
        for (int k = 0; k < N; k++) begin
            bus.unit_done[k] = pend[k];
            bus.unit_id[k]   = uid[k];
            bus.unit_rd[k]   = urd[k];
        end
        #1;
        ackSeen = bus.unit_ack;
        expAck  = '0;
        win     = -1;
        load    = !mValid || readyVal;
        if (!rstVal && load) begin
            for (int i = 0; i < N; i++) begin
                if (win < 0 && pend[(mPtr + i) % N]) begin
                    win = (mPtr + i) % N;
                end
            end
        end
        if (win >= 0) begin
            expAck[win] = 1'b1;
            e.pkt.id    = uid[win];
            e.pkt.rd    = urd[win];
            e.unit      = win;
            expQ.push_back(e);
        end
        checkOutput("unit_ack", ackSeen, expAck);
        @(posedge clk);
        if (rstVal) begin
            mValid = 1'b0;
            mPtr   = 0;
            expQ.delete();
        end else if (load) begin
            mValid = (win >= 0);
            if (win >= 0) begin
                pend[win] = 1'b0;
                mPtr      = (win + 1) % N;
            end
        end
    endtask

    task automatic present(input int k, input id_t id, input logic [31:0] rd);
        pend[k] = 1'b1;
        uid[k]  = id;
        urd[k]  = rd;
    endtask

    // Monitor: every result leaving the stage must be the oldest queued one.
    initial begin
        expEntry_t e;
        forever begin
            @(negedge clk);
            #3;
            if (monEn) begin
                checkOutput("wb_valid", bus.wb_valid, mValid);
                if (!rst && bus.wb_valid && bus.wb_ready) begin
                    if (expQ.size() == 0) begin
                        nCompared++;
                        nMismatched++;
                        $display("[TB] FAIL scoreboard: unexpected output from unit %0d, expected nothing", bus.wb_unit);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("wb_id", bus.wb_id, e.pkt.id);
                        checkOutput("wb_rd", bus.wb_rd, e.pkt.rd);
                        checkOutput("wb_unit", bus.wb_unit, e.unit);
                    end
                end
            end
        end
    end

    // Unit contract: a pending result may only drop after it was acked.
    always @(posedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (prevDone[k] && !prevAck[k]) begin
                assert (bus.unit_done[k])
                else $error("[TB] protocol violation: unit %0d dropped done before ack", k);
            end
        end
        prevDone = bus.unit_done;
        prevAck  = bus.unit_ack;
    end

    initial begin
        logic [N-1:0] ack;
        int           order[5] = '{1, 2, 3, 0, 1};
        bus.wb_ready  = 1'b0;
        bus.unit_done = '0;
        bus.unit_id   = '0;
        bus.unit_rd   = '0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 1'b0;
            uid[k]  = '0;
            urd[k]  = '0;
        end

        // Reset with every unit requesting
        for (int k = 0; k < N; k++) present(k, id_t'(k + 8), 32'h1000_0000 + k);
        applyStimulus(1'b1, 1'b1, ack);
        checkOutput("reset ack c0", ack, 4'b0000);
        monEn = 1'b1;
        applyStimulus(1'b1, 1'b1, ack);
        checkOutput("reset ack c1", ack, 4'b0000);
        #1;
        checkOutput("reset wb_valid", bus.wb_valid, 0);
        checkOutput("reset wb_id", bus.wb_id, 0);
        checkOutput("reset wb_rd", bus.wb_rd, 0);
        checkOutput("reset wb_unit", bus.wb_unit, 0);

        // First grant after reset, then full contention
        applyStimulus(1'b0, 1'b1, ack);
        checkOutput("first grant", ack, 4'b0001);
        present(0, 4'h1, 32'h2000_0000);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b1, ack);
            checkOutput("contention order", ack, 4'b0001 << order[i]);
            for (int k = 0; k < N; k++) begin
                if (ack[k] && i < 4) present(k, id_t'($urandom), $urandom);
            end
        end
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, ack);

        // Single request from unit 2
        present(2, 4'd5, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 1'b1, ack);
        checkOutput("single ack", ack, 4'b0100);
        #1;
        checkOutput("single wb_valid", bus.wb_valid, 1);
        checkOutput("single wb_id", bus.wb_id, 5);
        checkOutput("single wb_rd", bus.wb_rd, 32'hDEAD_BEEF);
        checkOutput("single wb_unit", bus.wb_unit, 2);

        // Backpressure: hold unit 1's result while unit 3 waits
        present(1, 4'd7, 32'h1111_1111);
        applyStimulus(1'b0, 1'b1, ack);
        checkOutput("bp load unit1", ack, 4'b0010);
        present(3, 4'd9, 32'h3333_3333);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, ack);
            checkOutput("bp ack held", ack, 4'b0000);
            #1;
            checkOutput("bp wb_unit held", bus.wb_unit, 1);
            checkOutput("bp wb_rd held", bus.wb_rd, 32'h1111_1111);
        end
        applyStimulus(1'b0, 1'b1, ack);
        checkOutput("bp release ack", ack, 4'b1000);
        #1;
        checkOutput("bp wb_unit next", bus.wb_unit, 3);

        // Wrap-around: pointer wrapped to 0 after granting unit 3
        present(0, 4'd2, 32'hAAAA_0000);
        present(3, 4'd3, 32'hBBBB_3333);
        applyStimulus(1'b0, 1'b1, ack);
        checkOutput("wrap first", ack, 4'b0001);
        applyStimulus(1'b0, 1'b1, ack);
        checkOutput("wrap second", ack, 4'b1000);

        // Reset mid-operation with a held entry and unit 2 pending
        present(2, 4'd6, 32'hCAFE_0002);
        applyStimulus(1'b0, 1'b0, ack);
        checkOutput("midrst pre ack", ack, 4'b0000);
        applyStimulus(1'b1, 1'b0, ack);
        checkOutput("midrst ack", ack, 4'b0000);
        #1;
        checkOutput("midrst wb_valid", bus.wb_valid, 0);
        applyStimulus(1'b0, 1'b0, ack);
        checkOutput("midrst regrant", ack, 4'b0100);

        // Randomized traffic with backpressure and occasional reset
        for (int c = 0; c < 600; c++) begin
            applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 70), ack);
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 99) < 40) present(k, id_t'($urandom), $urandom);
            end
        end

        // Drain everything still pending or held
        for (int c = 0; c < 12; c++) applyStimulus(1'b0, 1'b1, ack);
        checkOutput("drain queue empty", expQ.size(), 0);
        checkOutput("drain wb_valid", bus.wb_valid, 0);

        monEn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
